// File: rtl/reg_bank_dump_streamer_if.sv
// Valid/ready stream carrying one register-bank word per handshake.
// m_index is one bit wider than a register select so it can also name the checksum slot.
interface reg_bank_dump_streamer_if #(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned REGS_QTY    = 32
);
  localparam int unsigned IDXW = $clog2(REGS_QTY) + 1;

  logic [DATA_LENGTH-1:0] m_data;
  logic [IDXW-1:0]        m_index;
  logic                   m_valid;
  logic                   m_ready;
  logic                   m_last;

  modport master (output m_data, m_index, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_index, m_valid, m_last, output m_ready);
endinterface

// File: rtl/reg_bank_dump_streamer.sv
// Snapshots the register bank on start and streams it word by word over a valid/ready port.
// Optional REG_DUMP_CHECKSUM_EN appends an XOR checksum word after the last register.
module reg_bank_dump_streamer #(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned REGS_QTY    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [REGS_QTY*DATA_LENGTH-1:0] regs_q,
  reg_bank_dump_streamer_if.master        m,
  output logic                            busy,
  output logic                            done
);
  localparam int unsigned IDXW = $clog2(REGS_QTY) + 1;
  localparam int unsigned SELW = $clog2(REGS_QTY);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(REGS_QTY - 1);
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
  typedef enum logic [1:0] {IDLE, SEND, CSUM, DONE} state_t;
`else
  localparam bit CSUM_EN = 1'b0;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

  state_t                                 state_q, state_d;
  logic [REGS_QTY-1:0][DATA_LENGTH-1:0]   snap_q;
  logic                                   snap_ld;
  logic [DATA_LENGTH-1:0]                 data_q, data_d;
  logic [IDXW-1:0]                        idx_q, idx_d;
  logic                                   last_q, last_d;
  logic                                   valid_q, busy_q, done_q;
  logic                                   fire;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_LENGTH-1:0]                 acc_q, acc_d;
`endif

  assign fire = valid_q & m.m_ready;

  // Next-state and next-output values; output flops load these every cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    snap_ld = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          snap_ld = 1'b1;
          idx_d   = '0;
          data_d  = regs_q[DATA_LENGTH-1:0];
          last_d  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      SEND: begin
        if (fire) begin
`ifdef REG_DUMP_CHECKSUM_EN
          acc_d = acc_q ^ data_q;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_d = CSUM;
            idx_d   = IDXW'(REGS_QTY);
            data_d  = acc_q ^ data_q;
            last_d  = 1'b1;
`else
            state_d = DONE;
            idx_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
`endif
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = snap_q[SELW'(idx_d)];
            last_d = !CSUM_EN && (idx_d == LAST_IDX);
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        if (fire) begin
          state_d = DONE;
          idx_d   = '0;
          data_d  = '0;
          last_d  = 1'b0;
        end
      end
`endif
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        data_d  = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (snap_ld) snap_q <= regs_q;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
`ifdef REG_DUMP_CHECKSUM_EN
      valid_q <= (state_d == SEND) || (state_d == CSUM);
      acc_q   <= acc_d;
`else
      valid_q <= (state_d == SEND);
`endif
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign m.m_data  = data_q;
  assign m.m_index = idx_q;
  assign m.m_valid = valid_q;
  assign m.m_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_reg_bank_dump_streamer.sv
// Scoreboard bench for reg_bank_dump_streamer: expected words queued at start, monitor pops on handshake.
module tb_reg_bank_dump_streamer;
  localparam int unsigned DL   = 32;
  localparam int unsigned RQ   = 32;
  localparam int unsigned IDXW = $clog2(RQ) + 1;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
  localparam int unsigned NW = RQ + 1;
`else
  localparam bit CSUM_EN = 1'b0;
  localparam int unsigned NW = RQ;
`endif
  // XOR of the standard bank contents, worked out by hand.
  localparam logic [DL-1:0] CSUM_VAL = 32'hA5A4_8141;

  typedef struct packed {
    logic [DL-1:0]   data;
    logic [IDXW-1:0] index;
    logic            last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [RQ*DL-1:0]   regs_q;
  logic               busy, done;
  logic [DL-1:0]      bank [RQ];

  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   words_acc = 0;
  int   done_cnt = 0;
  bit   rdy_toggle = 1'b0;

  reg_bank_dump_streamer_if #(.DATA_LENGTH(DL), .REGS_QTY(RQ)) bus ();

  reg_bank_dump_streamer #(.DATA_LENGTH(DL), .REGS_QTY(RQ)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .regs_q (regs_q),
    .m      (bus),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < int'(RQ); i++) regs_q[i*DL +: DL] = bank[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Ready driver: held high, or the repeating 1,0,0,1 pattern.
  initial begin : ready_drv
    int ph;
    ph = 0;
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) begin
        bus.m_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        bus.m_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor: pops expected words on handshake and checks stall stability.
  initial begin : monitor
    bit   stall;
    exp_t held, e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        check("stall_valid", 64'(bus.m_valid), 64'd1);
        check("stall_data", 64'(bus.m_data), 64'(held.data));
        check("stall_index", 64'(bus.m_index), 64'(held.index));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(bus.m_index), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 64'(bus.m_data), 64'(e.data));
          check("word_index", 64'(bus.m_index), 64'(e.index));
          check("word_last", 64'(bus.m_last), 64'(e.last));
        end
        words_acc++;
        stall = 1'b0;
      end else if (bus.m_valid) begin
        stall = 1'b1;
        held.data  = bus.m_data;
        held.index = bus.m_index;
        held.last  = bus.m_last;
      end else begin
        stall = 1'b0;
      end
      if (done) done_cnt++;
    end
  end

  task automatic load_bank();
    for (int i = 0; i < int'(RQ); i++) bank[i] = 32'hA5A5_0000 + DL'(i);
    bank[0] = 32'h0;
    bank[2] = 32'h1001_0140;
    bank[3] = 32'h1000_8000;
  endtask

  task automatic push_dump();
    exp_t e;
    for (int i = 0; i < int'(RQ); i++) begin
      e.data  = bank[i];
      e.index = IDXW'(i);
      e.last  = !CSUM_EN && (i == int'(RQ) - 1);
      exp_q.push_back(e);
    end
    if (CSUM_EN) begin
      e.data  = CSUM_VAL;
      e.index = IDXW'(RQ);
      e.last  = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Queues the expected dump, pulses start, and checks the one-cycle latency.
  task automatic start_dump(input string tag);
    words_acc = 0;
    done_cnt  = 0;
    push_dump();
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    check({tag, "_valid_before"}, 64'(bus.m_valid), 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check({tag, "_valid_latency"}, 64'(bus.m_valid), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic finish_dump(input string tag);
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_done_after"}, 64'(done), 64'd0);
    repeat (4) @(negedge clk);
    check({tag, "_word_count"}, 64'(words_acc), 64'(NW));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : stim
    int n;
    bit hit;
    rst   = 1'b1;
    start = 1'b0;
    load_bank();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(bus.m_valid), 64'd0);
    check("rst_index", 64'(bus.m_index), 64'd0);
    check("rst_data", 64'(bus.m_data), 64'd0);
    check("rst_last", 64'(bus.m_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Full-rate dump: words back to back, done right after the last one.
    start_dump("s1");
    wait_done("s1", 200, n);
    check("s1_done_cycle", 64'(n), 64'(NW));
    finish_dump("s1");

    // Stalling consumer.
    rdy_toggle = 1'b1;
    start_dump("s2");
    wait_done("s2", 400, n);
    finish_dump("s2");
    rdy_toggle = 1'b0;

    // Bank write during the dump must not leak into the stream.
    start_dump("s3");
    @(negedge clk);
    bank[5] = 32'hDEAD_BEEF;
    wait_done("s3", 200, n);
    finish_dump("s3");
    load_bank();

    // Start while busy is ignored.
    rdy_toggle = 1'b1;
    start_dump("s4");
    hit = 1'b0;
    n = 0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.m_valid && bus.m_index == IDXW'(10)) hit = 1'b1;
    end
    check("s4_reach_10", 64'(hit), 64'd1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("s4", 400, n);
    finish_dump("s4");
    rdy_toggle = 1'b0;
    repeat (4) @(negedge clk);
    check("s4_no_restart", 64'(busy), 64'd0);

    // Reset mid-dump aborts without a done pulse.
    start_dump("s5");
    hit = 1'b0;
    n = 0;
    while (!hit && n < 100) begin
      if (bus.m_valid && bus.m_index == IDXW'(17)) hit = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("s5_reach_17", 64'(hit), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("s5_valid", 64'(bus.m_valid), 64'd0);
    check("s5_busy", 64'(busy), 64'd0);
    check("s5_done", 64'(done), 64'd0);
    check("s5_index", 64'(bus.m_index), 64'd0);
    check("s5_no_done_pulse", 64'(done_cnt), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    start_dump("s6");
    wait_done("s6", 200, n);
    check("s6_done_cycle", 64'(n), 64'(NW));
    finish_dump("s6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "timeout");
  end
endmodule
